// File: rtl/fifo_stream_pkg.sv
// Shared constants and types for the FIFO stream drain.
package fifo_stream_pkg;

    localparam int BUF_DEPTH = 2;
    localparam int PKT_CNT_W = 16;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_stream_drain_if.sv
// Valid/ready stream carrying one word per beat with an end-of-packet marker.
interface fifo_stream_drain_if #(
    parameter int WIDTH = 8
);

    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/stream_skid_buf.sv
// Two-entry circular buffer that absorbs the FIFO read latency.
module stream_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output occ_t             occ,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;

    // Storage, pointers and occupancy; flush empties the buffer but leaves storage as is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            occ    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Head entry is always presented; it is only meaningful when occ != 0.
    always_comb begin
        head_data = mem[rd_ptr];
    end

endmodule

// File: rtl/fifo_stream_drain.sv
// Drains a registered-output FIFO into a packetised valid/ready stream.
module fifo_stream_drain
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fifo_empty,
    output logic                 fifo_rd,
    input  logic [WIDTH-1:0]     fifo_data,
    input  logic                 flush,
    fifo_stream_drain_if.master  m,
    output logic [PKT_CNT_W-1:0] pkt_count
);

    localparam int                BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    occ_t              occ;
    logic [WIDTH-1:0]  head_data;
    logic              inflight;
    logic              drop;
    logic              xfer;
    logic              push;
    logic              pop;
    logic [2:0]        credit;
    logic [BEAT_W-1:0] beat;

    // Pop only when the buffer can still hold everything already owed to it.
    always_comb begin
        xfer    = m.m_valid && m.m_ready;
        credit  = 3'(occ) + 3'(inflight) - 3'(xfer);
        fifo_rd = !fifo_empty && !flush && (credit < 3'(BUF_DEPTH));
        push    = inflight && !flush && !drop;
        pop     = xfer && !flush;
    end

    // Track the word on fifo_data and mark the cycle after a flush for discard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            drop     <= 1'b0;
        end else begin
            inflight <= fifo_rd;
            drop     <= flush;
        end
    end

    stream_skid_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (fifo_data),
        .pop       (pop),
        .flush     (flush),
        .occ       (occ),
        .head_data (head_data)
    );

    // Stream outputs come straight from the buffer head.
    always_comb begin
        m.m_valid = (occ != '0);
        m.m_data  = head_data;
        m.m_last  = m.m_valid && (beat == LAST_BEAT);
    end

    // Beat position within the packet and completed-packet count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat      <= '0;
            pkt_count <= '0;
        end else if (flush) begin
            beat <= '0;
        end else if (xfer) begin
            if (m.m_last) begin
                beat      <= '0;
                pkt_count <= pkt_count + 1'b1;
            end else begin
                beat <= beat + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Directed bench: one instance with 4-word packets, one with single-word packets.
module tb_fifo_stream_drain;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance A: PKT_LEN = 4, memory-backed FIFO model
    fifo_stream_drain_if #(.WIDTH(8)) if_a ();
    logic        fifo_empty_a;
    logic        fifo_rd_a;
    logic [7:0]  fifo_data_a;
    logic        flush_a = 1'b0;
    logic [15:0] pkt_a;
    logic [7:0]  mem_a [64];
    int          head_a = 0;
    int          tail_a = 0;

    assign fifo_empty_a = (head_a == tail_a);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data_a <= '0;
            head_a      <= tail_a;
        end else if (fifo_rd_a && !fifo_empty_a) begin
            fifo_data_a <= mem_a[head_a];
            head_a      <= head_a + 1;
        end
    end

    fifo_stream_drain #(.WIDTH(8), .PKT_LEN(4)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty_a),
        .fifo_rd    (fifo_rd_a),
        .fifo_data  (fifo_data_a),
        .flush      (flush_a),
        .m          (if_a.master),
        .pkt_count  (pkt_a)
    );

    task automatic load_a(input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            mem_a[tail_a + k] = base + 8'(k);
        end
        tail_a = tail_a + n;
    endtask

    // ---------------- instance B: PKT_LEN = 1, counter-backed FIFO model
    fifo_stream_drain_if #(.WIDTH(8)) if_b ();
    logic        fifo_empty_b;
    logic        fifo_rd_b;
    logic [7:0]  fifo_data_b;
    logic [15:0] pkt_b;
    int          head_b = 0;
    int          tail_b = 0;
    logic [7:0]  exp_b = 8'h61;
    int          bad_b = 0;

    assign fifo_empty_b = (head_b == tail_b);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data_b <= '0;
            head_b      <= tail_b;
        end else if (fifo_rd_b && !fifo_empty_b) begin
            fifo_data_b <= 8'(head_b + 'h61);
            head_b      <= head_b + 1;
        end
    end

    fifo_stream_drain #(.WIDTH(8), .PKT_LEN(1)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty_b),
        .fifo_rd    (fifo_rd_b),
        .fifo_data  (fifo_data_b),
        .flush      (1'b0),
        .m          (if_b.master),
        .pkt_count  (pkt_b)
    );

    // Ordering scoreboard for B: accepted words must follow 0x61, 0x62, ...
    always @(negedge clk) begin
        if (rst_n && if_b.m_valid && if_b.m_ready) begin
            if (if_b.m_data != exp_b) bad_b++;
            exp_b <= exp_b + 8'd1;
        end
    end

    initial begin
        int idle;
        int budget;

        if_a.m_ready = 1'b1;
        if_b.m_ready = 1'b1;

        // Reset values
        tick();
        tick();
        check("rst_fifo_rd", fifo_rd_a, 0);
        check("rst_valid", if_a.m_valid, 0);
        check("rst_data", if_a.m_data, 0);
        check("rst_last", if_a.m_last, 0);
        check("rst_pkt", pkt_a, 0);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_rd", fifo_rd_a, 0);

        // Streaming 0x10..0x17
        load_a(8'h10, 8);
        #1;
        check("stream_rd0", fifo_rd_a, 1);
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            check("stream_valid", if_a.m_valid, 1);
            check("stream_data", if_a.m_data, 32'h10 + 32'(i));
            check("stream_last", if_a.m_last, (i % 4 == 3) ? 1 : 0);
            tick();
        end
        check("stream_pkt", pkt_a, 2);
        check("stream_drained", if_a.m_valid, 0);

        // Back-pressure over 0x20..0x27
        load_a(8'h20, 8);
        #1;
        check("bp_rd0", fifo_rd_a, 1);
        tick();
        tick();
        check("bp_d20", if_a.m_data, 32'h20);
        tick();
        check("bp_d21", if_a.m_data, 32'h21);
        tick();
        if_a.m_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("bp_hold_valid", if_a.m_valid, 1);
            check("bp_hold_data", if_a.m_data, 32'h22);
            check("bp_hold_last", if_a.m_last, 0);
            check("bp_hold_rd", fifo_rd_a, 0);
            tick();
        end
        if_a.m_ready = 1'b1;
        #1;
        check("bp_release_rd", fifo_rd_a, 1);
        for (int i = 2; i < 8; i++) begin
            check("bp_valid", if_a.m_valid, 1);
            check("bp_data", if_a.m_data, 32'h20 + 32'(i));
            check("bp_last", if_a.m_last, (i == 3 || i == 7) ? 1 : 0);
            tick();
        end
        check("bp_pkt", pkt_a, 4);
        check("bp_drained", if_a.m_valid, 0);

        // Flush with a word in flight
        if_a.m_ready = 1'b0;
        load_a(8'h30, 8);
        #1;
        check("fl_rd0", fifo_rd_a, 1);
        tick();
        tick();
        tick();
        check("fl_d30", if_a.m_data, 32'h30);
        if_a.m_ready = 1'b1;
        #1;
        check("fl_full_rd", fifo_rd_a, 1);
        tick();
        if_a.m_ready = 1'b0;
        flush_a = 1'b1;
        #1;
        check("fl_cycle_rd", fifo_rd_a, 0);
        tick();
        flush_a = 1'b0;
        check("fl_after_valid", if_a.m_valid, 0);
        tick();
        tick();
        if_a.m_ready = 1'b1;
        for (int i = 3; i < 7; i++) begin
            check("fl_valid", if_a.m_valid, 1);
            check("fl_data", if_a.m_data, 32'h30 + 32'(i));
            check("fl_last", if_a.m_last, (i == 6) ? 1 : 0);
            tick();
        end
        check("fl_d37", if_a.m_data, 32'h37);
        check("fl_pkt", pkt_a, 5);
        tick();
        check("fl_drained", if_a.m_valid, 0);

        // Asynchronous reset mid-stream
        load_a(8'h40, 8);
        tick();
        tick();
        tick();
        check("mid_valid_pre", if_a.m_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", if_a.m_valid, 0);
        check("mid_rst_data", if_a.m_data, 0);
        check("mid_rst_last", if_a.m_last, 0);
        check("mid_rst_rd", fifo_rd_a, 0);
        check("mid_rst_pkt", pkt_a, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_rd", fifo_rd_a, 0);
        check("post_rst_valid", if_a.m_valid, 0);
        load_a(8'h50, 4);
        #1;
        check("post_rst_rd1", fifo_rd_a, 1);
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            check("post_rst_data", if_a.m_data, 32'h50 + 32'(i));
            check("post_rst_last", if_a.m_last, (i == 3) ? 1 : 0);
            tick();
        end
        check("post_rst_pkt", pkt_a, 1);

        // PKT_LEN = 1: three single-word packets
        tail_b = 3;
        #1;
        check("p1_rd0", fifo_rd_b, 1);
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            check("p1_valid", if_b.m_valid, 1);
            check("p1_data", if_b.m_data, 32'h61 + 32'(i));
            check("p1_last", if_b.m_last, 1);
            tick();
        end
        check("p1_pkt", pkt_b, 3);

        // Wrap: 65537 packets in total on instance B
        tail_b = 65537;
        idle = 0;
        budget = 0;
        while (idle < 3 && budget < 70000) begin
            tick();
            budget++;
            if (head_b == tail_b && !if_b.m_valid) idle++;
            else idle = 0;
        end
        check("wrap_timeout", (budget < 70000) ? 1 : 0, 1);
        check("wrap_pkt", pkt_b, 1);
        check("wrap_order", bad_b, 0);
        check("wrap_words", exp_b, 32'h62);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
